// File: rtl/ram_responder_if.sv
// Request/response bundle between a memory requester (cache or memory
// controller) and the RAM responder.
interface ram_responder_if;
   logic [31:0] memaddr;
   logic [31:0] memstore;
   logic        memREN;
   logic        memWEN;
   logic [31:0] ramload;
   logic [1:0]  ramstate;

   modport master (
      output memaddr, memstore, memREN, memWEN,
      input  ramload, ramstate
   );

   modport slave (
      input  memaddr, memstore, memREN, memWEN,
      output ramload, ramstate
   );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM endpoint with a configurable number of wait states.
// A request is latched in FREE, must be held unchanged through BUSY, and is
// performed on the edge that enters ACCESS. Bad addresses and simultaneous
// read/write requests produce a one-cycle ERROR with no memory side effect.
module ram_responder #(
   parameter int         DEPTH  = 1024,
   parameter int         LAT    = 2,
   parameter logic [1:0] FREE   = 2'd0,
   parameter logic [1:0] BUSY   = 2'd1,
   parameter logic [1:0] ACCESS = 2'd2,
   parameter logic [1:0] ERROR  = 2'd3
) (
   input  logic           CLK,
   input  logic           RST,
   ram_responder_if.slave bus
);
   localparam int IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_FREE   = FREE,
      S_BUSY   = BUSY,
      S_ACCESS = ACCESS,
      S_ERROR  = ERROR
   } state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic [29:0] req_addr, req_addr_n;
   logic [31:0] req_data, req_data_n;
   logic        req_wr, req_wr_n;
   logic        acc_go;
   logic        match;
   logic [29:0] word_in;
   logic [31:0] ramload;
   logic [31:0] mem [DEPTH];

   // Byte-offset bits of the address carry no meaning for word storage.
   logic unused_bits;
   assign unused_bits = ^bus.memaddr[1:0];

   assign word_in = bus.memaddr[31:2];

   // A held request matches only if type, word and (for writes) data are
   // unchanged; both enables asserted can never match a latched request.
   assign match = (bus.memREN == !req_wr) && (bus.memWEN == req_wr) &&
                  (word_in == req_addr) &&
                  (!req_wr || (bus.memstore == req_data));

   // Next-state, request latching and access strobe.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      req_addr_n = req_addr;
      req_data_n = req_data;
      req_wr_n   = req_wr;
      acc_go     = 1'b0;
      case (state)
         S_FREE: begin
            if (bus.memREN && bus.memWEN) begin
               state_n = S_ERROR;
            end else if (bus.memREN || bus.memWEN) begin
               if (word_in >= 30'(DEPTH)) begin
                  state_n = S_ERROR;
               end else begin
                  req_addr_n = word_in;
                  req_data_n = bus.memstore;
                  req_wr_n   = bus.memWEN;
                  if (LAT == 0) begin
                     state_n = S_ACCESS;
                     acc_go  = 1'b1;
                  end else begin
                     state_n = S_BUSY;
                     cnt_n   = 4'(LAT - 1);
                  end
               end
            end
         end
         S_BUSY: begin
            if (!match) begin
               state_n = S_FREE;
            end else if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               state_n = S_ACCESS;
               acc_go  = 1'b1;
            end
         end
         S_ACCESS: state_n = S_FREE;
         S_ERROR:  state_n = S_FREE;
         default:  state_n = S_FREE;
      endcase
   end

   // State, wait counter, request latches and read-data register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_FREE;
         cnt      <= 4'd0;
         req_addr <= 30'd0;
         req_data <= 32'd0;
         req_wr   <= 1'b0;
         ramload  <= 32'd0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         req_addr <= req_addr_n;
         req_data <= req_data_n;
         req_wr   <= req_wr_n;
         if (acc_go && !req_wr_n) begin
            ramload <= mem[req_addr_n[IW-1:0]];
         end
      end
   end

   // Storage write; reset suppresses a write that has not yet committed.
   always_ff @(posedge CLK) begin
      if (acc_go && req_wr_n && !RST) begin
         mem[req_addr_n[IW-1:0]] <= req_data_n;
      end
   end

   assign bus.ramstate = state;
   assign bus.ramload  = ramload;
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: one LAT=2 instance for most scenarios
// and one LAT=0 instance for back-to-back accesses.
module tb_ram_responder;
   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_BUSY   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_ERROR  = 2'd3;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   failures = 0;

   ram_responder_if bus_a();
   ram_responder_if bus_b();

   ram_responder #(.DEPTH(1024), .LAT(2)) dut_a (.CLK(CLK), .RST(RST), .bus(bus_a));
   ram_responder #(.DEPTH(1024), .LAT(0)) dut_b (.CLK(CLK), .RST(RST), .bus(bus_b));

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drop_a();
      bus_a.memREN = 1'b0;
      bus_a.memWEN = 1'b0;
   endtask

   // Full LAT=2 access on instance A: returns state and ramload seen in the
   // cycle where ACCESS is expected, then releases the request for one cycle.
   task automatic access_a(input logic wr, input logic [31:0] addr,
                           input logic [31:0] data,
                           output logic [1:0] st, output logic [31:0] ld);
      bus_a.memaddr  = addr;
      bus_a.memstore = data;
      bus_a.memWEN   = wr;
      bus_a.memREN   = !wr;
      step();
      step();
      step();
      st = bus_a.ramstate;
      ld = bus_a.ramload;
      drop_a();
      step();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus_a.memREN = 1'b1;
      bus_a.memaddr = 32'h40;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (bus_a.ramstate !== ST_FREE) begin
            failures++;
            $display("FAIL reset_state cyc%0d got=%0d exp=%0d", i, bus_a.ramstate, ST_FREE);
         end
         checks++;
         if (bus_a.ramload !== 32'h0) begin
            failures++;
            $display("FAIL reset_ramload cyc%0d got=%h exp=%h", i, bus_a.ramload, 32'h0);
         end
      end
      RST = 1'b0;
      step();
      checks++;
      if (bus_a.ramstate !== ST_BUSY) begin
         failures++;
         $display("FAIL reset_first_busy got=%0d exp=%0d", bus_a.ramstate, ST_BUSY);
      end
      drop_a();
      step();
      checks++;
      if (bus_a.ramstate !== ST_FREE) begin
         failures++;
         $display("FAIL reset_drop_free got=%0d exp=%0d", bus_a.ramstate, ST_FREE);
      end
   endtask

   task automatic test_write_read();
      logic [1:0]  exp_seq [4];
      logic [1:0]  st;
      logic [31:0] ld;
      exp_seq[0] = ST_BUSY; exp_seq[1] = ST_BUSY; exp_seq[2] = ST_ACCESS; exp_seq[3] = ST_FREE;
      bus_a.memaddr  = 32'h10;
      bus_a.memstore = 32'hDEADBEEF;
      bus_a.memWEN   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bus_a.ramstate !== exp_seq[i]) begin
            failures++;
            $display("FAIL write_seq cyc%0d got=%0d exp=%0d", i, bus_a.ramstate, exp_seq[i]);
         end
         if (i == 2) drop_a();
      end
      bus_a.memaddr = 32'h10;
      bus_a.memREN  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (bus_a.ramstate !== exp_seq[i]) begin
            failures++;
            $display("FAIL read_seq cyc%0d got=%0d exp=%0d", i, bus_a.ramstate, exp_seq[i]);
         end
         if (i == 2) begin
            checks++;
            if (bus_a.ramload !== 32'hDEADBEEF) begin
               failures++;
               $display("FAIL read_data got=%h exp=%h", bus_a.ramload, 32'hDEADBEEF);
            end
            drop_a();
         end
      end
      access_a(1'b0, 32'h13, 32'h0, st, ld);
      checks++;
      if (st !== ST_ACCESS || ld !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL read_unaligned got=%0d/%h exp=%0d/%h", st, ld, ST_ACCESS, 32'hDEADBEEF);
      end
      checks++;
      if (bus_a.ramload !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL ramload_hold got=%h exp=%h", bus_a.ramload, 32'hDEADBEEF);
      end
   endtask

   task automatic test_abort();
      logic [1:0]  st;
      logic [31:0] ld;
      access_a(1'b1, 32'h20, 32'hA5A50020, st, ld);
      bus_a.memaddr  = 32'h20;
      bus_a.memstore = 32'h1;
      bus_a.memWEN   = 1'b1;
      step();
      step();
      checks++;
      if (bus_a.ramstate !== ST_BUSY) begin
         failures++;
         $display("FAIL abort_busy2 got=%0d exp=%0d", bus_a.ramstate, ST_BUSY);
      end
      bus_a.memaddr = 32'h24;
      step();
      checks++;
      if (bus_a.ramstate !== ST_FREE) begin
         failures++;
         $display("FAIL abort_free got=%0d exp=%0d", bus_a.ramstate, ST_FREE);
      end
      step();
      step();
      checks++;
      if (bus_a.ramstate !== ST_BUSY) begin
         failures++;
         $display("FAIL abort_rebusy got=%0d exp=%0d", bus_a.ramstate, ST_BUSY);
      end
      step();
      checks++;
      if (bus_a.ramstate !== ST_ACCESS) begin
         failures++;
         $display("FAIL abort_reaccess got=%0d exp=%0d", bus_a.ramstate, ST_ACCESS);
      end
      drop_a();
      step();
      access_a(1'b0, 32'h24, 32'h0, st, ld);
      checks++;
      if (ld !== 32'h1) begin
         failures++;
         $display("FAIL abort_new_word got=%h exp=%h", ld, 32'h1);
      end
      access_a(1'b0, 32'h20, 32'h0, st, ld);
      checks++;
      if (ld !== 32'hA5A50020) begin
         failures++;
         $display("FAIL abort_old_word got=%h exp=%h", ld, 32'hA5A50020);
      end
   endtask

   task automatic test_errors();
      logic [1:0]  st;
      logic [31:0] ld;
      logic [31:0] prev;
      prev = bus_a.ramload;
      bus_a.memaddr = 32'h1000;
      bus_a.memREN  = 1'b1;
      step();
      checks++;
      if (bus_a.ramstate !== ST_ERROR) begin
         failures++;
         $display("FAIL range_error got=%0d exp=%0d", bus_a.ramstate, ST_ERROR);
      end
      drop_a();
      step();
      checks++;
      if (bus_a.ramstate !== ST_FREE) begin
         failures++;
         $display("FAIL range_after got=%0d exp=%0d", bus_a.ramstate, ST_FREE);
      end
      bus_a.memaddr  = 32'h10;
      bus_a.memstore = 32'h12345678;
      bus_a.memREN   = 1'b1;
      bus_a.memWEN   = 1'b1;
      step();
      checks++;
      if (bus_a.ramstate !== ST_ERROR) begin
         failures++;
         $display("FAIL both_error got=%0d exp=%0d", bus_a.ramstate, ST_ERROR);
      end
      checks++;
      if (bus_a.ramload !== prev) begin
         failures++;
         $display("FAIL both_ramload got=%h exp=%h", bus_a.ramload, prev);
      end
      drop_a();
      step();
      checks++;
      if (bus_a.ramstate !== ST_FREE) begin
         failures++;
         $display("FAIL both_after got=%0d exp=%0d", bus_a.ramstate, ST_FREE);
      end
      access_a(1'b0, 32'h10, 32'h0, st, ld);
      checks++;
      if (ld !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL both_mem got=%h exp=%h", ld, 32'hDEADBEEF);
      end
   endtask

   task automatic test_back_to_back();
      bus_b.memaddr  = 32'h8;
      bus_b.memstore = 32'hCAFE0008;
      bus_b.memWEN   = 1'b1;
      step();
      checks++;
      if (bus_b.ramstate !== ST_ACCESS) begin
         failures++;
         $display("FAIL lat0_write got=%0d exp=%0d", bus_b.ramstate, ST_ACCESS);
      end
      bus_b.memWEN = 1'b0;
      step();
      bus_b.memREN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (bus_b.ramstate !== ((i % 2 == 0) ? ST_ACCESS : ST_FREE)) begin
            failures++;
            $display("FAIL lat0_pattern cyc%0d got=%0d exp=%0d", i, bus_b.ramstate,
                     (i % 2 == 0) ? ST_ACCESS : ST_FREE);
         end
         if (i % 2 == 0) begin
            checks++;
            if (bus_b.ramload !== 32'hCAFE0008) begin
               failures++;
               $display("FAIL lat0_data cyc%0d got=%h exp=%h", i, bus_b.ramload, 32'hCAFE0008);
            end
         end
      end
      bus_b.memREN = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_busy();
      logic [1:0]  st;
      logic [31:0] ld;
      access_a(1'b1, 32'h30, 32'h0BADF00D, st, ld);
      bus_a.memaddr  = 32'h30;
      bus_a.memstore = 32'h55;
      bus_a.memWEN   = 1'b1;
      step();
      checks++;
      if (bus_a.ramstate !== ST_BUSY) begin
         failures++;
         $display("FAIL rstbusy_busy got=%0d exp=%0d", bus_a.ramstate, ST_BUSY);
      end
      RST = 1'b1;
      step();
      checks++;
      if (bus_a.ramstate !== ST_FREE) begin
         failures++;
         $display("FAIL rstbusy_free got=%0d exp=%0d", bus_a.ramstate, ST_FREE);
      end
      RST = 1'b0;
      drop_a();
      step();
      access_a(1'b0, 32'h30, 32'h0, st, ld);
      checks++;
      if (ld !== 32'h0BADF00D) begin
         failures++;
         $display("FAIL rstbusy_mem got=%h exp=%h", ld, 32'h0BADF00D);
      end
   endtask

   initial begin
      bus_a.memaddr = 32'h0; bus_a.memstore = 32'h0; bus_a.memREN = 1'b0; bus_a.memWEN = 1'b0;
      bus_b.memaddr = 32'h0; bus_b.memstore = 32'h0; bus_b.memREN = 1'b0; bus_b.memWEN = 1'b0;
      test_reset();
      test_write_read();
      test_abort();
      test_errors();
      test_back_to_back();
      test_reset_mid_busy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the `cpu_ram_if` protocol: the RAM model that answers the cache/memory-control request port (`memaddr`, `memstore`, `memREN`, `memWEN`) with `ramload` and `ramstate`. It holds a word-addressed storage array and applies a configurable wait-state latency to every access. It reports range and protocol errors. It is the simulation and FPGA RAM endpoint behind the processor top level, and the target against which the memory controller is verified.

## Interface
Parameters:
- `DEPTH`, 1024: storage size in 32-bit words; must be a power of two, at least 2.
- `LAT`, 2: wait states (BUSY cycles) before ACCESS; range 0–15.
- `FREE`, 2'd0; `BUSY`, 2'd1; `ACCESS`, 2'd2; `ERROR`, 2'd3: the `ramstate` encoding.

Ports:
- `CLK` in 1: clock; all logic on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `memaddr` in 32: byte address; `[1:0]` ignored; word index is `memaddr[31:2]`.
- `memstore` in 32: write data.
- `memREN` in 1: read request.
- `memWEN` in 1: write request.
- `ramload` out 32: read data; valid while `ramstate==ACCESS` after a read.
- `ramstate` out 2: responder state (FREE/BUSY/ACCESS/ERROR).

## Operation
- Registered state machine with states FREE, BUSY, ACCESS and ERROR. `ramstate` is the state register. The block also holds latch registers `req_addr`, `req_data`, `req_wr` and a 4-bit wait counter `cnt`.
- FREE, no request (`memREN`=`memWEN`=0): stay in FREE.
- FREE, both `memREN` and `memWEN` asserted: go to ERROR.
- FREE, word index ≥ `DEPTH`: go to ERROR.
- FREE, valid request: latch address, data and type.
  - If `LAT`==0, go to ACCESS and perform the access on this same edge.
  - Otherwise go to BUSY with `cnt`=`LAT`-1.
- BUSY: compare the live inputs against the latched request (addr[31:2], REN, WEN; data only for writes).
  - Mismatch or request dropped: go to FREE and abandon the access; there is no memory side effect.
  - Match and `cnt`≠0: decrement `cnt`.
  - Match and `cnt`==0: go to ACCESS and perform the access on this edge.
- Performing the access:
  - Write: `mem[req_addr]`←`req_data`.
  - Read: `ramload`←`mem[req_addr]`.
- ACCESS lasts exactly one cycle, then the block unconditionally goes to FREE. A request still held during ACCESS is not a new request until the block is back in FREE. This gives one idle FREE cycle minimum between accesses.
- ERROR lasts one cycle, then goes to FREE. There is no memory side effect.
- `ramload` holds its last read value through all other states, including after writes and errors.
- Storage is not cleared by `RST`; contents are undefined until written. Word-addressed storage uses `$clog2(DEPTH)` index bits.

## Timing
- Reset: `ramstate`=FREE, `ramload`=0, `cnt`=0, latches=0. `RST` mid-access returns the block to FREE the next edge. A write that has not yet reached its ACCESS-entering edge is dropped.
- Latency:
  - The request is sampled at edge E0.
  - `ramstate` is BUSY for `LAT` cycles, then ACCESS for the cycle after edge E`LAT`.
  - With `LAT`=0, ACCESS appears in the cycle after E0.
- Handshake rule: the requester holds addr, type and (for writes) data stable from E0 until it observes ACCESS. It deasserts or changes the request in the ACCESS cycle or later.
- Simultaneous REN and WEN is always ERROR, checked only in FREE. A change to both asserted during BUSY counts as a mismatch, so the block goes to FREE.
- Read-after-write to the same word in back-to-back accesses returns the new data. Each access completes before the next one is sampled.

## Test plan
- Reset: assert `RST` for 2 cycles with `memREN`=1 → `ramstate`=FREE and `ramload`=0 throughout; the first BUSY appears one cycle after `RST` falls.
- Write then read, `LAT`=2:
  - Write 0xDEADBEEF to 0x0000_0010 → BUSY, BUSY, ACCESS, FREE.
  - Read 0x0000_0010 → BUSY ×2, then ACCESS with `ramload`=0xDEADBEEF.
  - Read 0x0000_0013 → same word, same data.
- Abort: start a write of 0x1 to 0x20, change `memaddr` to 0x24 in the second BUSY cycle → FREE next, then a fresh BUSY ×2 and ACCESS for 0x24. A later read of 0x20 returns its prior value.
- Errors, `DEPTH`=1024:
  - Read of 0x0000_1000 → ERROR for one cycle, then FREE.
  - REN=WEN=1 → ERROR; the memory is unchanged and `ramload` is unchanged.
- `LAT`=0 back-to-back: hold a read of 0x8 continuously → pattern ACCESS, FREE, ACCESS, FREE…, with `ramload` valid in each ACCESS cycle.
- Reset mid-BUSY: write 0x55 to 0x30, assert `RST` in the first BUSY cycle → FREE next; a later read of 0x30 does not return 0x55.
